// File: rtl/msrv32_ahb_pkg.sv
// Shared AHB-Lite encodings and the data-master state type.
package msrv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StErr,
    StRespErr
  } ahb_state_e;

endpackage

// File: rtl/msrv32_ahb_size_decode.sv
// Maps a store byte mask, or a load size plus address offset, onto AHB hsize,
// the low address bits and an illegal-mask flag. Purely combinational.
module msrv32_ahb_size_decode
  import msrv32_ahb_pkg::*;
(
  input  logic       is_wr_i,
  input  logic [3:0] wr_mask_i,
  input  logic [1:0] load_size_i,
  input  logic [1:0] addr_lo_i,
  output logic [2:0] hsize_o,
  output logic [1:0] offset_o,
  output logic       illegal_o
);

  // Only naturally aligned byte, half and word masks are transferable.
  always_comb begin
    hsize_o   = HSIZE_WORD;
    offset_o  = 2'd0;
    illegal_o = 1'b0;
    if (is_wr_i) begin
      case (wr_mask_i)
        4'b1111: begin hsize_o = HSIZE_WORD; offset_o = 2'd0; end
        4'b0011: begin hsize_o = HSIZE_HALF; offset_o = 2'd0; end
        4'b1100: begin hsize_o = HSIZE_HALF; offset_o = 2'd2; end
        4'b0001: begin hsize_o = HSIZE_BYTE; offset_o = 2'd0; end
        4'b0010: begin hsize_o = HSIZE_BYTE; offset_o = 2'd1; end
        4'b0100: begin hsize_o = HSIZE_BYTE; offset_o = 2'd2; end
        4'b1000: begin hsize_o = HSIZE_BYTE; offset_o = 2'd3; end
        default: illegal_o = 1'b1;
      endcase
    end else begin
      offset_o = addr_lo_i;
      case (load_size_i)
        2'b00:   hsize_o = HSIZE_BYTE;
        2'b01:   hsize_o = HSIZE_HALF;
        default: hsize_o = HSIZE_WORD;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_ahb_data_master.sv
// AHB-Lite master for the core data port: one NONSEQ transfer per request,
// with wait-state and two-cycle ERROR handling. All outputs are registered.
// Optional macro MSRV32_AHB_TIMEOUT_EN adds a watchdog on stalled hready_in.
module msrv32_ahb_data_master
  import msrv32_ahb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_req_in,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [3:0]        wr_mask_in,
  input  logic [1:0]        load_size_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic              hwrite_out,
  output logic [2:0]        hsize_out,
  output logic [1:0]        htrans_out,
  output logic [DATA_W-1:0] hwdata_out,
  input  logic [DATA_W-1:0] hrdata_in,
  input  logic              hready_in,
  input  logic              hresp_in
);

  if (DATA_W != 32 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("msrv32_ahb_data_master: DATA_W must be 32 and TIMEOUT_CYCLES nonzero");
  end

  ahb_state_e        state_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        dec_hsize;
  logic [1:0]        dec_offset;
  logic              dec_illegal;

`ifdef MSRV32_AHB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q;
`endif

  // Write wins when both requests are raised together.
  msrv32_ahb_size_decode u_size_decode (
    .is_wr_i     (wr_req_in),
    .wr_mask_i   (wr_mask_in),
    .load_size_i (load_size_in),
    .addr_lo_i   (addr_in[1:0]),
    .hsize_o     (dec_hsize),
    .offset_o    (dec_offset),
    .illegal_o   (dec_illegal)
  );

  // Transfer sequencer; every bus and core-side output is a register here.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      wdata_q    <= '0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      err_out    <= 1'b0;
      rdata_out  <= '0;
      haddr_out  <= '0;
      hwrite_out <= 1'b0;
      hsize_out  <= HSIZE_BYTE;
      htrans_out <= HTRANS_IDLE;
      hwdata_out <= '0;
`ifdef MSRV32_AHB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // done_out high means the core has not yet dropped the old request.
          if ((wr_req_in || rd_req_in) && !done_out) begin
            busy_out <= 1'b1;
            wdata_q  <= wdata_in;
            if (wr_req_in && dec_illegal) begin
              state_q <= StRespErr;
            end else begin
              state_q    <= StAddr;
              htrans_out <= HTRANS_NONSEQ;
              haddr_out  <= {addr_in[ADDR_W-1:2], dec_offset};
              hsize_out  <= dec_hsize;
              hwrite_out <= wr_req_in;
            end
          end
        end
        StAddr: begin
          if (hready_in) begin
            state_q    <= StData;
            htrans_out <= HTRANS_IDLE;
            if (hwrite_out) hwdata_out <= wdata_q;
          end
        end
        StData: begin
          if (hresp_in) begin
            if (hready_in) begin
              // Single-cycle ERROR is a protocol violation; complete as failed.
              state_q  <= StIdle;
              busy_out <= 1'b0;
              done_out <= 1'b1;
              err_out  <= 1'b1;
            end else begin
              state_q <= StErr;
            end
          end else if (hready_in) begin
            state_q  <= StIdle;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            if (!hwrite_out) rdata_out <= hrdata_in;
          end
        end
        StErr: begin
          if (hready_in) begin
            state_q  <= StIdle;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            err_out  <= 1'b1;
          end
        end
        StRespErr: begin
          state_q  <= StIdle;
          busy_out <= 1'b0;
          done_out <= 1'b1;
          err_out  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
`ifdef MSRV32_AHB_TIMEOUT_EN
      // Watchdog overrides the case above when the bus has stalled too long.
      if ((state_q == StAddr || state_q == StData || state_q == StErr) && !hready_in) begin
        if (tmo_q == TmoLast) begin
          tmo_q      <= '0;
          state_q    <= StIdle;
          htrans_out <= HTRANS_IDLE;
          busy_out   <= 1'b0;
          done_out   <= 1'b1;
          err_out    <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_data_master.sv
// Directed and randomized bench for msrv32_ahb_data_master. The bench plays
// the core and the AHB slave; expected addresses, sizes and cycle timing come
// from a small transfer-level model of the access rules.
module tb_msrv32_ahb_data_master;
  import msrv32_ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [31:0] addr, wdata, hrdata;
  logic [3:0]  wr_mask;
  logic [1:0]  load_size;
  logic        hready, hresp;
  logic        busy_o, done_o, err_o, hwrite_o;
  logic [31:0] rdata_o, haddr_o, hwdata_o;
  logic [2:0]  hsize_o;
  logic [1:0]  htrans_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_ahb_data_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .wr_req_in    (wr_req),
    .rd_req_in    (rd_req),
    .addr_in      (addr),
    .wdata_in     (wdata),
    .wr_mask_in   (wr_mask),
    .load_size_in (load_size),
    .busy_out     (busy_o),
    .done_out     (done_o),
    .err_out      (err_o),
    .rdata_out    (rdata_o),
    .haddr_out    (haddr_o),
    .hwrite_out   (hwrite_o),
    .hsize_out    (hsize_o),
    .htrans_out   (htrans_o),
    .hwdata_out   (hwdata_o),
    .hrdata_in    (hrdata),
    .hready_in    (hready),
    .hresp_in     (hresp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transfer-level access rules: a store is legal only if its mask covers one
  // naturally aligned byte, half or word; the lowest lane gives the offset.
  function automatic void model(input bit wr, input logic [31:0] a, input logic [3:0] m,
                                input logic [1:0] ls, output bit legal,
                                output logic [31:0] ea, output logic [2:0] es);
    int pop;
    int low;
    if (!wr) begin
      legal = 1'b1;
      ea    = a;
      es    = (ls == 2'd3) ? 3'd2 : {1'b0, ls};
      return;
    end
    pop = $countones(m);
    low = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) low = i;
    legal = (pop == 4) || (pop == 1) || (pop == 2 && low % 2 == 0 && m[low+1]);
    es    = (pop == 4) ? 3'd2 : (pop == 2) ? 3'd1 : 3'd0;
    ea    = {a[31:2], 2'(pop == 4 ? 0 : low)};
  endfunction

  // One full request: aw address-phase waits, dw data-phase waits,
  // em 0 = OKAY, 1 = two-cycle ERROR, 2 = single-cycle ERROR.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input logic [1:0] ls, input int aw,
                     input int dw, input int em, input logic [31:0] rd);
    bit          legal;
    logic [31:0] ea;
    logic [2:0]  es;
    model(wr, a, m, ls, legal, ea, es);
    wr_req = wr; rd_req = !wr; addr = a; wdata = wd; wr_mask = m; load_size = ls;
    hready = 1'b1; hresp = 1'b0;
    check("idle_busy", busy_o, 0);
    step();
    check("accept_busy", busy_o, 1);
    if (!legal) begin
      check("rerr_htrans", htrans_o, HTRANS_IDLE);
      check("rerr_done_early", done_o, 0);
      step();
      check("rerr_htrans2", htrans_o, HTRANS_IDLE);
      check("rerr_done", done_o, 1);
      check("rerr_err", err_o, 1);
    end else begin
      check("a_htrans", htrans_o, HTRANS_NONSEQ);
      check("a_haddr", haddr_o, ea);
      check("a_hsize", hsize_o, es);
      check("a_hwrite", hwrite_o, wr);
      for (int i = 0; i < aw; i++) begin
        hready = 1'b0;
        step();
      end
      check("a_hold_htrans", htrans_o, HTRANS_NONSEQ);
      check("a_hold_haddr", haddr_o, ea);
      hready = 1'b1;
      step();
      check("d_htrans", htrans_o, HTRANS_IDLE);
      if (wr) check("d_hwdata", hwdata_o, wd);
      for (int i = 0; i < dw; i++) begin
        hready = 1'b0;
        step();
        check("d_wait_done", done_o, 0);
      end
      if (em == 1) begin
        hresp = 1'b1; hready = 1'b0;
        step();
        check("e1_done", done_o, 0);
        hready = 1'b1;
        step();
      end else if (em == 2) begin
        hresp = 1'b1; hready = 1'b1;
        step();
      end else begin
        hready = 1'b1; hrdata = rd;
        step();
      end
      hresp = 1'b0; hready = 1'b1;
      check("done", done_o, 1);
      check("err", err_o, (em != 0) ? 1 : 0);
      check("done_busy", busy_o, 0);
      if (!wr && em == 0) check("rdata", rdata_o, rd);
    end
    // Request still high during the done cycle must not be re-accepted.
    step();
    check("post_done", done_o, 0);
    check("post_busy", busy_o, 0);
    check("post_htrans", htrans_o, HTRANS_IDLE);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    int          aw, dw, em;
    bit          wr;
    logic [3:0]  m;
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; addr = '0; wdata = '0;
    wr_mask = '0; load_size = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    #1;
    check("rst_htrans", htrans_o, 0);
    check("rst_haddr", haddr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_hsize", hsize_o, 0);
    step();
    rst_n = 1'b1;
    step();

    txn(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 2'd0, 0, 0, 0, 32'h0);
    txn(1'b0, 32'h203, 32'h0, 4'b0000, 2'd0, 0, 2, 0, 32'h11223344);
    txn(1'b1, 32'h40, 32'hAABB0000, 4'b1100, 2'd0, 0, 0, 0, 32'h0);
    txn(1'b1, 32'h80, 32'h12345678, 4'b0101, 2'd0, 0, 0, 0, 32'h0);
    txn(1'b0, 32'h300, 32'h0, 4'b0000, 2'd2, 0, 1, 1, 32'h0);
    txn(1'b0, 32'h304, 32'h0, 4'b0000, 2'd2, 0, 0, 0, 32'hCAFEF00D);
    txn(1'b1, 32'h55, 32'h00FF0000, 4'b0100, 2'd0, 2, 0, 2, 32'h0);
    txn(1'b1, 32'h13, 32'h0000FFFF, 4'b0011, 2'd0, 1, 1, 0, 32'h0);
    txn(1'b1, 32'h20, 32'h0, 4'b1110, 2'd0, 0, 0, 0, 32'h0);

    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      m  = 4'($urandom);
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      em = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      txn(wr, $urandom, $urandom, m, 2'($urandom_range(0, 2)), aw, dw, em, $urandom);
    end

    // Asynchronous reset in the middle of a stalled data phase.
    wr_req = 1'b0; rd_req = 1'b1; addr = 32'h400; load_size = 2'd2; hready = 1'b1;
    step();
    step();
    hready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_htrans", htrans_o, 0);
    check("arst_haddr", haddr_o, 0);
    check("arst_hwdata", hwdata_o, 0);
    check("arst_rdata", rdata_o, 0);
    check("arst_hsize", hsize_o, 0);
    check("arst_hwrite", hwrite_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_err", err_o, 0);
    rd_req = 1'b0; hready = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_no_done", done_o, 0);
    end
    txn(1'b0, 32'h402, 32'h0, 4'b0000, 2'd1, 0, 0, 0, 32'h5A5AA5A5);

`ifdef MSRV32_AHB_TIMEOUT_EN
    // Bus never ready: watchdog completes with error after four low cycles.
    wr_req = 1'b1; addr = 32'h500; wdata = 32'h1; wr_mask = 4'b1111; hready = 1'b1;
    step();
    check("tmo_htrans", htrans_o, HTRANS_NONSEQ);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tmo_early", done_o, 0);
    end
    step();
    check("tmo_done", done_o, 1);
    check("tmo_err", err_o, 1);
    check("tmo_htrans_idle", htrans_o, HTRANS_IDLE);
    wr_req = 1'b0; hready = 1'b1;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
